phase_enable_gen: RTL

Synthesisable multi-phase sequencer for the core. From a single clock it produces NUM_PHASES rotating phase-enable strobes, a post-reset core_reset hold, a completed-round counter and a stop flag at a programmable round limit. It replaces derived, skewed phase clocks with clock enables in one domain. Pause and single-step controls support debug.

---
 rtl/phase_enable_gen.sv | 127 ++++++++++++
 1 files changed

// File: rtl/phase_enable_gen.sv
// Multi-phase clock-enable sequencer: rotating one-hot phase strobes,
// post-reset core hold, round counter and round-limit stop.
module phase_enable_gen #(
  parameter int NUM_PHASES = 3,
  parameter int PHASE_LEN  = 2,
  parameter int RST_HOLD   = 2,
  parameter int CNT_WIDTH  = 32,
  parameter int MAX_CYCLES = 0
) (
  input  logic                  clk1,
  input  logic                  reset,
  input  logic                  run,
  input  logic                  step,
  output logic [NUM_PHASES-1:0] phase_en,
  output logic [NUM_PHASES-1:0] phase_act,
  output logic                  core_reset,
  output logic [CNT_WIDTH-1:0]  cycle_count,
  output logic                  done
);

  localparam int PW = $clog2(NUM_PHASES);
  localparam int SW = (PHASE_LEN > 1) ? $clog2(PHASE_LEN) : 1;
  localparam int HW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

  localparam logic [PW-1:0] PH_LAST   = PW'(NUM_PHASES - 1);
  localparam logic [SW-1:0] SUB_LAST  = SW'(PHASE_LEN - 1);
  localparam logic [HW-1:0] HOLD_LAST =
    HW'((RST_HOLD > 0) ? RST_HOLD - 1 : 0);
  localparam logic [CNT_WIDTH-1:0] LIMIT = CNT_WIDTH'(MAX_CYCLES);
  localparam bit LIMIT_EN = (MAX_CYCLES != 0);
  localparam bit NO_HOLD  = (RST_HOLD == 0);

  typedef enum logic [1:0] {
    HOLD   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [HW-1:0]          hold_cnt_q, hold_cnt_d;
  logic [PW-1:0]          phase_idx_q, phase_idx_d;
  logic [SW-1:0]          sub_cnt_q, sub_cnt_d;
  logic [CNT_WIDTH-1:0]   cycle_count_q, cycle_count_d;
  logic                   done_q, done_d;

  logic                   tick;
  logic [NUM_PHASES-1:0]  onehot;
  logic [CNT_WIDTH-1:0]   cnt_inc;

  always_comb begin
    state_d       = state_q;
    hold_cnt_d    = hold_cnt_q;
    phase_idx_d   = phase_idx_q;
    sub_cnt_d     = sub_cnt_q;
    cycle_count_d = cycle_count_q;
    done_d        = done_q;
    tick          = 1'b0;
    core_reset    = 1'b0;
    phase_act     = '0;
    phase_en      = '0;
    onehot        = NUM_PHASES'(1) << phase_idx_q;
    cnt_inc       = cycle_count_q + 1'b1;

    unique case (state_q)
      HOLD: begin
        core_reset = 1'b1;
        hold_cnt_d = hold_cnt_q + 1'b1;
        if (NO_HOLD || hold_cnt_q == HOLD_LAST) begin
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        tick      = run | step;
        phase_act = onehot;
        if (tick && sub_cnt_q == '0) begin
          phase_en = onehot;
        end
        if (tick) begin
          if (sub_cnt_q != SUB_LAST) begin
            sub_cnt_d = sub_cnt_q + 1'b1;
          end else begin
            sub_cnt_d = '0;
            if (phase_idx_q != PH_LAST) begin
              phase_idx_d = phase_idx_q + 1'b1;
            end else begin
              // Round wrap: count it and stop at the limit
              phase_idx_d   = '0;
              cycle_count_d = cnt_inc;
              if (LIMIT_EN && cnt_inc == LIMIT) begin
                state_d = DONE;
                done_d  = 1'b1;
              end
            end
          end
        end
      end
      DONE: begin
        done_d = 1'b1;
      end
      default: begin
        state_d = HOLD;
      end
    endcase
  end

  always_ff @(posedge clk1) begin
    if (reset) begin
      state_q       <= HOLD;
      hold_cnt_q    <= '0;
      phase_idx_q   <= '0;
      sub_cnt_q     <= '0;
      cycle_count_q <= '0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      hold_cnt_q    <= hold_cnt_d;
      phase_idx_q   <= phase_idx_d;
      sub_cnt_q     <= sub_cnt_d;
      cycle_count_q <= cycle_count_d;
      done_q        <= done_d;
    end
  end

  assign cycle_count = cycle_count_q;
  assign done        = done_q;

endmodule
